// File: rtl/input_cmd_pkg.sv
// Shared types and constants for the I2C host/switch command front end.
package input_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int START_IDX  = 0;
  localparam int RW_IDX     = 1;
  localparam int RST_IDX    = 2;
  localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/input_cmd_decoder_bit_debouncer.sv
// One input bit: SYNC_STAGES-deep synchroniser followed by a stable-count debouncer.
module bit_debouncer
  import input_cmd_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_deb
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_deb;
  logic                   w_sync_out;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign o_deb      = r_deb;

  // The level is accepted on the DEBOUNCE_CYCLES-th consecutive mismatching edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_deb  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      if (w_sync_out == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_deb <= w_sync_out;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_cmd_decoder.sv
// Command register front end: debounced inputs, start-edge detect, valid/ready
// command issue toward the I2C master, soft-reset level and overrun counting.
module input_cmd_decoder #(
  parameter int IN_W            = 8,
  parameter int START_IDX       = input_cmd_pkg::START_IDX,
  parameter int RW_IDX          = input_cmd_pkg::RW_IDX,
  parameter int RST_IDX         = input_cmd_pkg::RST_IDX,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [IN_W-1:0]                      input_signals,
  input  logic                                 cmd_ready,
  input  logic                                 core_done,
  output logic                                 cmd_valid,
  output logic                                 cmd_rw,
  output logic                                 soft_reset,
  output logic                                 busy,
  output logic                                 dropped,
  output logic [input_cmd_pkg::DROP_CNT_W-1:0] drop_count,
  output logic [IN_W-1:0]                      debounced_signals
);
  import input_cmd_pkg::*;

  localparam int ARM_CYC = SYNC_STAGES + DEBOUNCE_CYCLES;
  localparam int ARM_W   = $clog2(ARM_CYC + 1);

  logic [IN_W-1:0]       w_deb;
  logic                  w_start_rise;
  logic                  w_soft;
  logic                  r_prev;
  logic                  r_armed;
  logic [ARM_W-1:0]      r_arm_cnt;

  state_t                r_state, w_state_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_rw,    w_rw_nxt;
  logic                  r_busy;
  logic                  r_dropped, w_drop;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  for (genvar g = 0; g < IN_W; g++) begin : g_bit
    bit_debouncer #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .i_raw (input_signals[g]),
      .o_deb (w_deb[g])
    );
  end

  // A start level already present at reset release debounces high exactly
  // ARM_CYC edges later; only a start seen low after that window may fire.
  assign w_start_rise = w_deb[START_IDX] & ~r_prev & r_armed;
  assign w_soft       = w_deb[RST_IDX];

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_rw_nxt    = r_rw;
    w_drop      = 1'b0;
    if (w_soft) begin
      w_state_nxt = IDLE;
      w_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_rise) begin
            w_rw_nxt    = w_deb[RW_IDX];
            w_valid_nxt = 1'b1;
            w_state_nxt = ISSUE;
          end
        end
        ISSUE: begin
          w_drop = w_start_rise;
          if (cmd_ready) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = WAIT;
          end
        end
        WAIT: begin
          w_drop = w_start_rise;
          if (core_done) w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_valid    <= 1'b0;
      r_rw       <= 1'b0;
      r_busy     <= 1'b0;
      r_dropped  <= 1'b0;
      r_drop_cnt <= '0;
      r_prev     <= 1'b0;
      r_armed    <= 1'b0;
      r_arm_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_valid   <= w_valid_nxt;
      r_rw      <= w_rw_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_dropped <= w_drop;
      r_prev    <= w_deb[START_IDX];
      if (r_arm_cnt != ARM_W'(ARM_CYC)) r_arm_cnt <= r_arm_cnt + 1'b1;
      else if (!w_deb[START_IDX])       r_armed   <= 1'b1;
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign cmd_valid         = r_valid;
  assign cmd_rw            = r_rw;
  assign soft_reset        = w_soft;
  assign busy              = r_busy;
  assign dropped           = r_dropped;
  assign drop_count        = r_drop_cnt;
  assign debounced_signals = w_deb;

endmodule

// File: tb/tb_input_cmd_decoder.sv
// Scoreboard bench for input_cmd_decoder with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_input_cmd_decoder;
  localparam int IN_W = 8;
  localparam int S    = 2;
  localparam int D    = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [IN_W-1:0] input_signals = '0;
  logic            cmd_ready = 1'b0;
  logic            core_done = 1'b0;
  logic            cmd_valid, cmd_rw, soft_reset, busy, dropped;
  logic [7:0]      drop_count;
  logic [IN_W-1:0] debounced_signals;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_drop_seen = 0;
  logic exp_q[$];
  logic sb_e;

  always #5 clk = ~clk;

  input_cmd_decoder #(
    .IN_W(IN_W), .START_IDX(0), .RW_IDX(1), .RST_IDX(2),
    .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .rst(rst), .input_signals(input_signals),
    .cmd_ready(cmd_ready), .core_done(core_done),
    .cmd_valid(cmd_valid), .cmd_rw(cmd_rw), .soft_reset(soft_reset),
    .busy(busy), .dropped(dropped), .drop_count(drop_count),
    .debounced_signals(debounced_signals)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (dropped) n_drop_seen++;
    end
  endtask

  task automatic wait_valid(input string tag, input int lim);
    for (int i = 0; i < lim && !cmd_valid; i++) step(1);
    chk(tag, cmd_valid, 1);
  endtask

  // Handshakes are sampled mid-cycle, where the next posedge will see them.
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
      else begin
        sb_e = exp_q.pop_front();
        chk("sb_rw", cmd_rw, sb_e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen, ok;
    logic [IN_W-1:0] dacc;

    step(3);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_rw", cmd_rw, 0);
    chk("rst_soft", soft_reset, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", dropped, 0);
    chk("rst_dcnt", drop_count, 0);
    chk("rst_deb", debounced_signals, 0);
    rst = 1'b0;
    step(10);

    // T1: latency 7 edges, single-cycle handshake with ready high
    cmd_ready = 1'b1;
    input_signals = 8'h03;
    exp_q.push_back(1'b1);
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk("t1_lat", cmd_valid, (k == 7));
      if (k == 7) chk("t1_busy", busy, 1);
    end
    core_done = 1'b1;
    step(1);
    core_done = 1'b0;
    chk("t1_busy_clr", busy, 0);
    chk("t1_rw_hold", cmd_rw, 1);

    // T2: 3-cycle start glitch is filtered
    input_signals = 8'h00;
    step(10);
    chk("t2_deb_low", debounced_signals, 0);
    input_signals = 8'h01;
    step(3);
    input_signals = 8'h00;
    seen = 1'b0;
    dacc = '0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      seen |= cmd_valid;
      dacc |= debounced_signals;
    end
    chk("t2_deb", dacc, 0);
    chk("t2_valid", seen, 0);

    // T3: hold without ready, overrun drops, saturation
    cmd_ready = 1'b0;
    input_signals = 8'h01;
    exp_q.push_back(1'b0);
    wait_valid("t3_issue", 20);
    n_drop_seen = 0;
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (!cmd_valid || cmd_rw) ok = 1'b0;
    end
    chk("t3_hold", ok, 1);
    input_signals = 8'h00;
    for (int k = 0; k < 8; k++) begin
      step(1);
      if (!cmd_valid || cmd_rw) ok = 1'b0;
    end
    input_signals = 8'h01;
    for (int k = 0; k < 8; k++) begin
      step(1);
      if (!cmd_valid || cmd_rw) ok = 1'b0;
    end
    chk("t3_hold_overrun", ok, 1);
    chk("t3_dropped", n_drop_seen, 1);
    chk("t3_dcnt1", drop_count, 1);
    cmd_ready = 1'b1;
    step(2);
    cmd_ready = 1'b0;
    chk("t3_valid_clr", cmd_valid, 0);
    chk("t3_busy_wait", busy, 1);
    for (int i = 0; i < 300; i++) begin
      input_signals = 8'h00;
      step(8);
      input_signals = 8'h01;
      step(8);
      if (i == 252) chk("t3_dcnt254", drop_count, 254);
      if (i == 253) chk("t3_dcnt255", drop_count, 255);
    end
    chk("t3_dcnt_sat", drop_count, 255);
    chk("t3_drop_pulses", n_drop_seen, 301);
    chk("t3_busy_still", busy, 1);

    // T4: soft reset from WAIT, start edges ignored while held
    input_signals = 8'h05;
    for (int k = 0; k < 20 && !soft_reset; k++) step(1);
    chk("t4_soft", soft_reset, 1);
    step(1);
    chk("t4_busy", busy, 0);
    chk("t4_valid", cmd_valid, 0);
    n_drop_seen = 0;
    seen = 1'b0;
    input_signals = 8'h04;
    for (int k = 0; k < 8; k++) begin step(1); seen |= cmd_valid | busy; end
    input_signals = 8'h05;
    for (int k = 0; k < 8; k++) begin step(1); seen |= cmd_valid | busy; end
    chk("t4_deb", debounced_signals, 8'h05);
    chk("t4_no_issue", seen, 0);
    chk("t4_no_drop", n_drop_seen, 0);
    chk("t4_dcnt", drop_count, 255);
    input_signals = 8'h01;
    step(10);
    chk("t4_soft_clr", soft_reset, 0);
    chk("t4_idle", busy, 0);

    // T5: rst mid-ISSUE, start held through reset must not refire
    input_signals = 8'h00;
    step(8);
    input_signals = 8'h01;
    wait_valid("t5_issue", 20);
    rst = 1'b1;
    step(1);
    chk("t5_valid", cmd_valid, 0);
    chk("t5_rw", cmd_rw, 0);
    chk("t5_soft", soft_reset, 0);
    chk("t5_busy", busy, 0);
    chk("t5_drop", dropped, 0);
    chk("t5_dcnt", drop_count, 0);
    chk("t5_deb", debounced_signals, 0);
    step(1);
    rst = 1'b0;
    cmd_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin step(1); seen |= cmd_valid | busy; end
    chk("t5_deb_held", debounced_signals, 8'h01);
    chk("t5_no_reissue", seen, 0);
    input_signals = 8'h00;
    step(10);
    exp_q.push_back(1'b0);
    input_signals = 8'h01;
    wait_valid("t5_rearm", 15);
    step(2);
    chk("t5_valid_done", cmd_valid, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
